// File: rtl/pe_tap_sequencer.sv
// pe_tap_sequencer: per-window control for the PE filter-buffer mux and MAC.
// For each output window it clears the MAC and steps the tap select across
// TAPS valid ifmap bytes, strobing the MAC enable on each one. It then captures
// the MAC result into a one-entry valid/ready output register. This repeats for
// the programmed number of windows, and done pulses when the job finishes.
//
// Ports:
//   clk_i          clock
//   rst_i          synchronous active-high reset
//   start_i        begin job (sampled only when idle)
//   num_win_i      windows in job, latched on accepted start
//   ifmap_valid_i  ifmap byte present on the MAC operand this cycle
//   ifmap_rd_o     consume ifmap byte (same as mac_en_o)
//   sel_o          tap select to the PE mux
//   mac_en_o       MAC accumulate enable
//   mac_rst_o      MAC accumulator clear
//   mac_out_i      PE MAC result
//   res_valid_o    result available
//   res_data_o     captured result
//   res_ready_i    consumer accepts result
//   busy_o         job in progress
//   done_o         one-cycle completion pulse
module pe_tap_sequencer #(
    parameter int unsigned TAPS  = 16,
    parameter int unsigned SEL_W = 4,
    parameter int unsigned OUT_W = 12,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] num_win_i,
    input  logic             ifmap_valid_i,
    output logic             ifmap_rd_o,
    output logic [SEL_W-1:0] sel_o,
    output logic             mac_en_o,
    output logic             mac_rst_o,
    input  logic [OUT_W-1:0] mac_out_i,
    output logic             res_valid_o,
    output logic [OUT_W-1:0] res_data_o,
    input  logic             res_ready_i,
    output logic             busy_o,
    output logic             done_o
);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StAccum,
        StSettle,
        StDrain
    } state_e;

    localparam logic [SEL_W-1:0] LastSel = SEL_W'(TAPS - 1);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             res_valid_q, res_valid_d;
    logic [OUT_W-1:0] res_data_q, res_data_d;
    logic             done_q, done_d;
    logic             mac_en, mac_rst, load, pop;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        mac_en  = 1'b0;
        mac_rst = 1'b0;
        load    = 1'b0;
        pop     = res_valid_q & res_ready_i;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    if (num_win_i != '0) begin
                        cnt_d   = num_win_i;
                        state_d = StClear;
                    end else begin
                        // Empty job: acknowledge immediately, never go busy.
                        done_d = 1'b1;
                    end
                end
            end
            StClear: begin
                mac_rst = 1'b1;
                sel_d   = '0;
                state_d = StAccum;
            end
            StAccum: begin
                mac_en = ifmap_valid_i;
                if (ifmap_valid_i) begin
                    if (sel_q == LastSel) begin
                        sel_d   = '0;
                        state_d = StSettle;
                    end else begin
                        sel_d = sel_q + 1'b1;
                    end
                end
            end
            StSettle: begin
                // Load when the result slot is free or drains on this same edge.
                if (!res_valid_q || res_ready_i) begin
                    load    = 1'b1;
                    cnt_d   = cnt_q - CNT_W'(1);
                    state_d = (cnt_q != CNT_W'(1)) ? StClear : StDrain;
                end
            end
            StDrain: begin
                if (pop) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        res_valid_d = load | (res_valid_q & ~res_ready_i);
        res_data_d  = load ? mac_out_i : res_data_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            sel_q       <= '0;
            cnt_q       <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            done_q      <= done_d;
        end
    end

    assign sel_o       = sel_q;
    assign mac_en_o    = mac_en;
    assign ifmap_rd_o  = mac_en;
    assign mac_rst_o   = mac_rst;
    assign res_valid_o = res_valid_q;
    assign res_data_o  = res_data_q;
    assign busy_o      = (state_q != StIdle);
    assign done_o      = done_q;

endmodule

// File: tb/tb_pe_tap_sequencer.sv
// Bench for pe_tap_sequencer: emulates the PE mux/MAC (taps 1..16) and checks
// each job against window sums computed directly from the ifmap data.
module tb_pe_tap_sequencer;
    localparam int TAPS  = 16;
    localparam int SEL_W = 4;
    localparam int OUT_W = 12;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] num_win;
    logic             ifmap_valid;
    logic             ifmap_rd;
    logic [SEL_W-1:0] sel;
    logic             mac_en;
    logic             mac_rst;
    logic [OUT_W-1:0] mac_out;
    logic             res_valid;
    logic [OUT_W-1:0] res_data;
    logic             res_ready;
    logic             busy;
    logic             done;
    logic [7:0]       ifmap_data;
    logic [OUT_W-1:0] acc = '0;
    int               taps [TAPS];

    int tests = 0;
    int fails = 0;

    typedef struct {
        int nw;
        int vmode;      // 0 always valid, 1 valid on odd cycles, 2 random
        int rmode;      // 0 always ready, 1 ready from rhold, 2 random
        int rhold;
        int dmode;      // 0 ifmap all ones, 1 random bytes
        int inj_cyc;    // cycle of an extra start pulse (0 = none)
        int inj_nw;
        int exp_first;  // cycle of first res_valid, -1 never, -2 unchecked
    } job_t;

    pe_tap_sequencer #(
        .TAPS (TAPS),
        .SEL_W(SEL_W),
        .OUT_W(OUT_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .num_win_i    (num_win),
        .ifmap_valid_i(ifmap_valid),
        .ifmap_rd_o   (ifmap_rd),
        .sel_o        (sel),
        .mac_en_o     (mac_en),
        .mac_rst_o    (mac_rst),
        .mac_out_i    (mac_out),
        .res_valid_o  (res_valid),
        .res_data_o   (res_data),
        .res_ready_i  (res_ready),
        .busy_o       (busy),
        .done_o       (done)
    );

    always #5 clk = ~clk;

    // PE MAC emulation: registered accumulator, tap weight selected by sel.
    always @(posedge clk) begin
        if (mac_rst) acc <= '0;
        else if (mac_en) acc <= acc + OUT_W'(taps[sel] * int'(ifmap_data));
    end
    assign mac_out = acc;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sel"}, sel, 0);
        check({tag, "_mac_en"}, mac_en, 0);
        check({tag, "_mac_rst"}, mac_rst, 0);
        check({tag, "_ifmap_rd"}, ifmap_rd, 0);
        check({tag, "_res_valid"}, res_valid, 0);
        check({tag, "_res_data"}, res_data, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    task automatic run_job(input job_t j);
        int xs [8][TAPS];
        int exp_res [8];
        int win, k, res_cnt, en_cnt, rd_err, first_valid, done_cnt, done_cyc;
        int last_acc, busy_seen, post, sum;
        logic prev_v, prev_r;
        logic [OUT_W-1:0] prev_d;
        for (int w = 0; w < 8; w++) begin
            sum = 0;
            for (int i = 0; i < TAPS; i++) begin
                xs[w][i] = (j.dmode == 0) ? 1 : int'($urandom_range(0, 255));
                sum += (i + 1) * xs[w][i];
            end
            exp_res[w] = sum % 4096;
        end
        win = 0; k = 0; res_cnt = 0; en_cnt = 0; rd_err = 0; first_valid = -1;
        done_cnt = 0; done_cyc = -1; last_acc = -1; busy_seen = 0; post = 0;
        prev_v = 1'b0; prev_r = 1'b0; prev_d = '0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            start   = (c == 0) || (j.inj_cyc != 0 && c == j.inj_cyc);
            num_win = (c == 0) ? CNT_W'(j.nw) : CNT_W'(j.inj_nw);
            case (j.vmode)
                0:       ifmap_valid = 1'b1;
                1:       ifmap_valid = ((c % 2) == 1);
                default: ifmap_valid = ($urandom_range(0, 9) < 7);
            endcase
            case (j.rmode)
                0:       res_ready = 1'b1;
                1:       res_ready = (c >= j.rhold);
                default: res_ready = 1'($urandom_range(0, 1));
            endcase
            ifmap_data = (win < 8) ? 8'(xs[win][k]) : 8'd0;
            #1;
            if (mac_en !== ifmap_rd) rd_err++;
            if (mac_en) begin
                check("sel_on_accum", sel, k);
                en_cnt++;
                k++;
                if (k == TAPS) begin
                    k = 0;
                    win++;
                end
            end
            if (busy) busy_seen = 1;
            if (res_valid && first_valid < 0) first_valid = c;
            if (prev_v && !prev_r) begin
                check("hold_valid", res_valid, 1);
                check("hold_data", res_data, prev_d);
            end
            if (res_valid && res_ready) begin
                if (res_cnt < 8) check("result", res_data, exp_res[res_cnt]);
                res_cnt++;
                last_acc = c;
            end
            if (done) begin
                done_cnt++;
                done_cyc = c;
                check("busy_at_done", busy, 0);
            end
            prev_v = res_valid;
            prev_r = res_ready;
            prev_d = res_data;
            if (done_cnt > 0) begin
                post++;
                if (post > 2) break;
            end
        end
        check("done_count", done_cnt, 1);
        check("result_count", res_cnt, j.nw);
        check("mac_en_count", en_cnt, TAPS * j.nw);
        check("rd_matches_en", rd_err, 0);
        check("busy_seen", busy_seen, (j.nw != 0) ? 1 : 0);
        check("done_cycle", done_cyc, (j.nw == 0) ? 1 : last_acc + 1);
        check("busy_after", busy, 0);
        if (j.exp_first != -2) check("first_valid_cycle", first_valid, j.exp_first);
        if (j.nw == 1 && j.dmode == 0) check("sum_1_to_16", prev_d, 136);
        start = 1'b0;
        ifmap_valid = 1'b0;
    endtask

    job_t tbl [6];
    job_t rj;

    initial begin
        for (int i = 0; i < TAPS; i++) taps[i] = i + 1;
        // nw vmode rmode rhold dmode inj_cyc inj_nw exp_first
        tbl[0] = '{1, 0, 0, 0, 0, 0, 0, 19};   // single window, no stalls
        tbl[1] = '{1, 1, 0, 0, 0, 0, 0, 35};   // ifmap_valid toggling
        tbl[2] = '{3, 0, 1, 60, 1, 0, 0, 19};  // backpressure until cycle 60
        tbl[3] = '{0, 0, 0, 0, 0, 0, 0, -1};   // zero windows
        tbl[4] = '{2, 0, 0, 0, 1, 5, 5, 19};   // start ignored while busy
        tbl[5] = '{2, 2, 2, 0, 1, 0, 0, -2};   // random valid/ready

        rst = 1'b1;
        start = 1'b0;
        num_win = '0;
        ifmap_valid = 1'b0;
        res_ready = 1'b0;
        ifmap_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        for (int t = 0; t < 6; t++) run_job(tbl[t]);

        // Reset during the second window's ACCUM while result 1 is held.
        for (int c = 0; c <= 28; c++) begin
            @(posedge clk);
            #1;
            start       = (c == 0);
            num_win     = 8'd2;
            ifmap_valid = 1'b1;
            res_ready   = 1'b0;
            ifmap_data  = 8'd1;
            rst         = (c == 27);
            #1;
            if (c == 27) begin
                check("pre_reset_sel", sel, 7);
                check("pre_reset_held", res_valid, 1);
            end
            if (c == 28) check_reset_outputs("mid_reset");
        end
        rst = 1'b0;
        ifmap_valid = 1'b0;
        run_job('{1, 0, 0, 0, 1, 0, 0, 19});

        for (int t = 0; t < 6; t++) begin
            rj = '{int'($urandom_range(1, 4)), 2, 2, 0, 1, 0, 0, -2};
            run_job(rj);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
